// File: rtl/gray_pkg.sv
// Shared mode constants and Gray-code conversion helpers for the gray codec pipeline.
// Helpers work on MAX_W-bit words; callers zero-extend narrower words before calling.
package gray_pkg;

  localparam int MAX_W = 64;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Resolves the prefix XOR for bits >= lo_base; bits below lo_base are returned raw.
  function automatic logic [MAX_W-1:0] gray2bin_hi(input logic [MAX_W-1:0] g,
                                                   input int lo_base);
    logic [MAX_W-1:0] r;
    logic acc;
    r   = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i >= lo_base) begin
        acc  = acc ^ g[i];
        r[i] = acc;
      end else begin
        r[i] = g[i];
      end
    end
    return r;
  endfunction

  // Finishes the bits below lo_base, seeded from the already-resolved bit lo_base.
  function automatic logic [MAX_W-1:0] gray2bin_lo(input logic [MAX_W-1:0] p,
                                                   input int lo_base);
    logic [MAX_W-1:0] r;
    logic acc;
    r   = '0;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < lo_base) begin
        acc  = acc ^ p[i];
        r[i] = acc;
      end else begin
        r[i] = p[i];
        acc  = p[i];
      end
    end
    return r;
  endfunction

  function automatic logic is_adjacent(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] d;
    int cnt;
    d   = a ^ b;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (d[i]) cnt++;
    end
    return cnt == 1;
  endfunction

endpackage

// File: rtl/gray_pipe_slice.sv
// Single-entry valid/ready register slice; full throughput when downstream is ready.
module gray_pipe_slice #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage streaming binary<->Gray converter with per-word mode and valid/ready handshake.
// Define GRAY_ADJ_CHECK_EN to flag Gray->binary inputs that are not adjacent to the previous one.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_err
);

  localparam int LO_BASE = WIDTH - SPLIT;
  localparam int SW      = WIDTH + 2;

  logic [WIDTH-1:0] s1_partial;
  logic             s1_err_d;
  logic [SW-1:0]    s1_q;
  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s2_result;
  logic [SW-1:0]    s2_q;
  logic             in_xfer;

  assign in_xfer = in_valid && in_ready;

  always_comb begin
    s1_partial = '0;
    if (in_mode == MODE_G2B) s1_partial = WIDTH'(gray2bin_hi(MAX_W'(in_data), LO_BASE));
    else                     s1_partial = WIDTH'(bin2gray(MAX_W'(in_data)));
  end

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;

  // Only Gray->binary words update the history; the first one after reset has nothing to compare to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
    end else if (in_xfer && in_mode == MODE_G2B) begin
      prev_gray <= in_data;
      have_prev <= 1'b1;
    end
  end

  assign s1_err_d = (in_mode == MODE_G2B) && have_prev &&
                    !is_adjacent(MAX_W'(in_data), MAX_W'(prev_gray));
`else
  assign s1_err_d = 1'b0;
`endif

  gray_pipe_slice #(.W(SW)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({s1_err_d, in_mode, s1_partial}),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_q)
  );

  always_comb begin
    s2_result = s1_q[WIDTH-1:0];
    if (s1_q[WIDTH] == MODE_G2B) s2_result = WIDTH'(gray2bin_lo(MAX_W'(s1_q[WIDTH-1:0]), LO_BASE));
  end

  gray_pipe_slice #(.W(SW)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  ({s1_q[WIDTH+1], s1_q[WIDTH], s2_result}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_q)
  );

  assign out_data = s2_q[WIDTH-1:0];
  assign out_mode = s2_q[WIDTH];
  assign out_err  = s2_q[WIDTH+1];

endmodule
